serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_addsub_if.sv | 24 ++
 rtl/serial_addsub_full_adder_cell.sv | 13 +
 rtl/serial_addsub.sv | 112 +++++++++++
 tb/tb_serial_addsub.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; never below 1 so the counter always has a bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Start/done handshake bundle between a host and the serial adder/subtractor.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_full_adder_cell.sv
// One-bit combinational full adder, the cell iterated by the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/sub, one bit per clock; done pulses WIDTH cycles after start is sampled.
// No queueing: start is ignored while busy, results hold until the next done.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             c;
  logic             c_msb_in;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] r_next;

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Result fills from the MSB so after WIDTH shifts bit 0 lands at R[0].
  assign r_next = {fa_s, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      c        <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // Subtraction as a + ~b + 1: the +1 enters through the carry flop.
            a_sr   <= bus.a;
            b_sr   <= bus.sub ? ~bus.b : bus.b;
            c      <= bus.sub;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_next;
          c    <= fa_c;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 2)) begin
            c_msb_in <= fa_c;
          end
          if (cnt == CW'(WIDTH - 1)) begin
            s_q    <= r_next;
            cout_q <= fa_c;
            ovf_q  <= fa_c ^ c_msb_in;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));
  a_busy_is_run: assert property (@(posedge clk) disable iff (!rst_n) busy_q == (state == RUN));

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with a queue-based scoreboard and done monitor.
module tb_serial_addsub;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    int           at;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc  = 0;
  int   busy_len = 0;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts negedges, tracks busy run length, scores each done pulse.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (bus.busy) busy_len = busy_prev ? busy_len + 1 : 1;
    busy_prev = bus.busy;
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", ncyc);
      end else begin
        e = sbq.pop_front();
        check({e.name, ".s"},       32'(bus.s),    32'(e.s));
        check({e.name, ".cout"},    32'(bus.cout), 32'(e.cout));
        check({e.name, ".ovf"},     32'(bus.ovf),  32'(e.ovf));
        check({e.name, ".latency"}, 32'(ncyc),     32'(e.at));
        check({e.name, ".busy_len"}, 32'(busy_len), 32'(W));
      end
    end
  end

  // Drive one start pulse; the done is expected W edges after the sampling edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input bit expect_it, input string name,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    if (expect_it) begin
      e.s = es; e.cout = ec; e.ovf = eo; e.at = ncyc + W + 1; e.name = name;
      sbq.push_back(e);
    end
    @(negedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    check({name, ".drain"}, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    int   d;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step(3);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.s",    32'(bus.s),    32'd0);
    check("reset.cout", 32'(bus.cout), 32'd0);
    check("reset.ovf",  32'(bus.ovf),  32'd0);
    rst_n = 1'b1;
    step(2);

    issue(8'h0F, 8'h01, 1'b0, 1'b1, "add_0f_01", 8'h10, 1'b0, 1'b0);
    drain("add_0f_01");
    issue(8'hFF, 8'h01, 1'b0, 1'b1, "add_ff_01", 8'h00, 1'b1, 1'b0);
    drain("add_ff_01");
    issue(8'h7F, 8'h01, 1'b0, 1'b1, "add_7f_01", 8'h80, 1'b0, 1'b1);
    drain("add_7f_01");
    issue(8'h05, 8'h07, 1'b1, 1'b1, "sub_05_07", 8'hFE, 1'b0, 1'b0);
    drain("sub_05_07");
    issue(8'h80, 8'h01, 1'b1, 1'b1, "sub_80_01", 8'h7F, 1'b1, 1'b1);
    drain("sub_80_01");

    // Start pulse mid-RUN with different operands must be ignored.
    issue(8'h01, 8'h01, 1'b0, 1'b1, "ignore_start", 8'h02, 1'b0, 1'b0);
    step(2);
    bus.start = 1'b1;
    bus.a     = 8'h11;
    step(1);
    bus.start = 1'b0;
    drain("ignore_start");
    step(12);
    check("ignore_start.s_held", 32'(bus.s), 32'h02);
    check("ignore_start.busy_idle", 32'(bus.busy), 32'd0);

    // Reset during RUN aborts with no done pulse.
    issue(8'h55, 8'h11, 1'b0, 1'b0, "abort", 8'h00, 1'b0, 1'b0);
    step(3);
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.s",    32'(bus.s),    32'd0);
    check("abort.cout", 32'(bus.cout), 32'd0);
    check("abort.ovf",  32'(bus.ovf),  32'd0);
    step(2);
    rst_n = 1'b1;
    step(12);
    check("abort.no_done_after", 32'(bus.done), 32'd0);
    issue(8'h03, 8'h04, 1'b0, 1'b1, "after_abort", 8'h07, 1'b0, 1'b0);
    drain("after_abort");

    // Back-to-back: second start presented during the DONE cycle.
    issue(8'h21, 8'h12, 1'b0, 1'b1, "b2b_first", 8'h33, 1'b0, 1'b0);
    d = ncyc - 1;
    for (int i = 0; i < 20 && ncyc < d + W + 1; i++) step(1);
    check("b2b.in_done_cycle", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.sub   = 1'b0;
    e.s = 8'h30; e.cout = 1'b0; e.ovf = 1'b0; e.at = d + 2 * (W + 1); e.name = "b2b_second";
    sbq.push_back(e);
    step(1);
    bus.start = 1'b0;
    drain("b2b");
    step(12);
    check("final.s_held", 32'(bus.s), 32'h30);
    check("final.queue_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
